adder_bist_ctrl: RTL
====================

# adder_bist_ctrl

Built-in self-test sequencer for the DFT-wrapped 16-bit ripple adder. On a start pulse it forces the wrapper into test mode and drives a counted sequence of broadcast stimulus bits. It folds the wrapper's compacted 6-bit response plus carry-out into an 8-bit MISR signature and reports pass/fail against a parameterised golden signature. It sits beside the adder wrapper and drives its select and bit-0 stimulus pins.

## Interface
- N, 16, adder width; informational, with no effect on sequencing.
- PAT_CNT, 16, number of patterns per session; legal range 1..65535.
- SIG_EXP, 8'h00, golden MISR signature.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  session request; sampled only in IDLE.
- abort  input  1  cancels a running session.
- resp  input  6  compacted response from the wrapper's test-mode output.
- resp_co  input  1  carry-out from the wrapper.
- test_sel  output  1  drives the wrapper select: 1 = test mode.
- test_a  output  1  drives the wrapper a-input bit 0 (broadcast source).
- test_b  output  1  drives the wrapper b-input bit 0 (broadcast source).
- busy  output  1  high in SETUP, RUN, FLUSH.
- done  output  1  one-cycle pulse when a session completes.
- pass  output  1  signature == SIG_EXP; valid from the done cycle.
- signature  output  8  current MISR value.

## Operation
- **Reset values.** All outputs are 0 and the state is IDLE.
- **States:** IDLE, SETUP, RUN, FLUSH, DONE.
- **IDLE.** start=1 moves to SETUP.
- **SETUP (1 cycle).**
  - test_sel=1 and busy=1.
  - MISR is cleared to 8'h00, the pattern counter to 0, and pass to 0.
- **RUN (PAT_CNT cycles).**
  - In the cycle with counter k: {test_a, test_b} = k[1:0], so the 00, 01, 10, 11 sequence repeats.
  - Counter width is $clog2(PAT_CNT+1).
  - The last pattern cycle moves to FLUSH.
- **Capture pipeline.**
  - At the end of every RUN cycle, resp and resp_co are registered into resp_q and co_q, and cap_vld is set.
  - While cap_vld=1, the MISR folds resp_q/co_q at the end of the following cycle.
- **FLUSH (1 cycle).** Performs the last MISR fold; the stimulus holds the final pattern. Then moves to DONE.
- **DONE (1 cycle).**
  - done=1, test_sel=0, busy=0.
  - pass = (signature == SIG_EXP), registered and held until the next SETUP.
  - Returns to IDLE.
- **MISR rule.** sig' = ({sig[6:0],1'b0} ^ (sig[7] ? 8'h1D : 8'h00)) ^ {1'b0, co_q, resp_q}.
- **Boundary behaviour.**
  - start while busy or in DONE: ignored.
  - abort in SETUP, RUN or FLUSH: IDLE next cycle; test_sel, busy and pass go to 0; no done pulse; signature holds its partial value; cap_vld is cleared.
  - abort in IDLE or DONE: no effect.
  - abort and start in the same IDLE cycle: start wins.
  - PAT_CNT=1: exactly one RUN cycle and one fold.
  - Asynchronous reset mid-session: all state and outputs return immediately to reset values.

## Timing
- Cycle c0: start is seen in IDLE.
- c1: SETUP.
- c2 .. c(PAT_CNT+1): RUN.
- c(PAT_CNT+2): FLUSH.
- c(PAT_CNT+3): DONE, with done=1.
- start-to-done latency is PAT_CNT+3 cycles.
- test_sel is high from c1 through c(PAT_CNT+2).
- The stimulus change at each edge must settle through the adder within one clock period, because the response is captured at the next edge.
- A back-to-back session is possible when start is asserted in the cycle after DONE.

## Structure
- Package adder_bist_pkg holds:
  - the state enum (IDLE, SETUP, RUN, FLUSH, DONE);
  - SIG_W = 8;
  - MISR_POLY = 8'h1D;
  - RESP_W = 6.
- Sub-module adder_bist_misr contains the MISR register. Ports: clk, rst_n, clr, en, din[6:0], sig[7:0].
- The FSM, pattern counter and capture registers stay in adder_bist_ctrl.

## Test plan
- Reset with rst_n=0 mid-RUN -> all outputs 0 immediately; after release a new start produces a full session.
- PAT_CNT=4, resp=6'h00, co=0, SIG_EXP=8'h00 -> done at c7, signature=8'h00, pass=1; test_a/test_b sequence 0/0, 0/1, 1/0, 1/1 in c2..c5.
- PAT_CNT=4, resp held at 6'h01, co=0, SIG_EXP=8'h0F -> signature progression 01, 03, 07, 0F; pass=1. Repeat with SIG_EXP=8'h0E -> pass=0.
- PAT_CNT=2, resp=6'h01 -> signature=8'h03 at done. Then start again in the cycle after DONE -> pass clears in SETUP, and the second session reaches 8'h03 again.
- abort asserted in the third RUN cycle -> IDLE next cycle, test_sel=0, no done pulse, pass=0; start during the aborted session is ignored.
- resp=6'h3F, co=1, PAT_CNT=2 -> sig 7F then 7F^FE = 81 at done. Confirms the polynomial is not applied when bit7=0, and the co bit lands in position 6.

Source files
------------

// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST controller.
// Holds the sequencer state encoding, MISR/response widths, the MISR
// feedback polynomial and the single-step MISR fold used by both the
// signature register and the pass-flag look-ahead.
package adder_bist_pkg;

  localparam int              SIG_W     = 8;
  localparam int              RESP_W    = 6;
  localparam logic [SIG_W-1:0] MISR_POLY = 8'h1D;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // One MISR step: shift left, apply the polynomial only when the bit
  // leaving the top was set, then XOR in the 7-bit response word.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [RESP_W:0]  din);
    logic [SIG_W-1:0] fb;
    fb = sig[SIG_W-1] ? MISR_POLY : '0;
    return ({sig[SIG_W-2:0], 1'b0} ^ fb) ^ {1'b0, din};
  endfunction

endpackage

// File: rtl/adder_bist_misr.sv
// 8-bit multiple-input signature register.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : fold din into the signature this cycle
//   din[6:0]   : {carry-out, 6-bit compacted response}
//   sig[7:0]   : current signature
module adder_bist_misr
  import adder_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [RESP_W:0]  din,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= misr_step(sig, din);
    end
  end

endmodule

// File: rtl/adder_bist_ctrl.sv
// BIST sequencer for the DFT-wrapped ripple adder.
// On start it puts the wrapper in test mode, drives a 2-bit repeating
// broadcast pattern for PAT_CNT cycles, captures the compacted response
// one cycle later and folds it into an 8-bit MISR, then pulses done and
// reports pass = (signature == SIG_EXP).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start, abort        : session request / cancel
//   resp[5:0], resp_co  : wrapper test-mode response and carry-out
//   test_sel            : wrapper test-mode select
//   test_a, test_b      : wrapper a/b bit-0 broadcast stimulus
//   busy, done, pass    : session status
//   signature[7:0]      : current MISR value
//
// state | meaning
// IDLE  | waiting for start
// SETUP | test mode on, clear MISR, counter and pass
// RUN   | drive pattern k, capture response; PAT_CNT cycles
// FLUSH | fold the last captured response, stimulus held
// DONE  | done pulse, pass flag valid, test mode off
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int               N       = 16,
  parameter int               PAT_CNT = 16,
  parameter logic [SIG_W-1:0] SIG_EXP = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [RESP_W-1:0] resp,
  input  logic              resp_co,
  output logic              test_sel,
  output logic              test_a,
  output logic              test_b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  localparam int            CW   = $clog2(PAT_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(PAT_CNT - 1);

  if (N < 1) begin : g_chk_n
    $error("adder_bist_ctrl: N must be at least 1");
  end
  if (PAT_CNT < 1 || PAT_CNT > 65535) begin : g_chk_pat
    $error("adder_bist_ctrl: PAT_CNT must be in 1..65535");
  end

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              last;
  logic [RESP_W-1:0] resp_q;
  logic              co_q;
  logic              cap_vld;
  logic              kill;
  logic              pat_on;
  logic [1:0]        pat;
  logic [SIG_W-1:0]  sig_fold;

  assign last     = (cnt == LAST);
  assign kill     = abort && busy;
  assign pat      = 2'(cnt);
  assign sig_fold = misr_step(signature, {co_q, resp_q});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = abort ? IDLE : RUN;
      RUN:     if (abort)     state_nxt = IDLE;
               else if (last) state_nxt = FLUSH;
      FLUSH:   state_nxt = abort ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    pat_on   = 1'b0;
    case (state)
      SETUP:   busy = 1'b1;
      RUN:     begin busy = 1'b1; pat_on = 1'b1; end
      FLUSH:   begin busy = 1'b1; pat_on = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
    test_sel = busy;
    test_a   = pat_on & pat[1];
    test_b   = pat_on & pat[0];
  end

  // Pattern counter; it stops on the last pattern so FLUSH keeps driving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == SETUP) begin
      cnt <= '0;
    end else if (state == RUN && !last) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Response capture: the adder settles during the RUN cycle and is
  // sampled at its closing edge; the fold happens one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q  <= '0;
      co_q    <= 1'b0;
      cap_vld <= 1'b0;
    end else begin
      cap_vld <= (state == RUN) && !abort;
      if (state == RUN) begin
        resp_q <= resp;
        co_q   <= resp_co;
      end
    end
  end

  // Pass is evaluated on the folded value entering DONE so that it is
  // already valid in the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass <= 1'b0;
    end else if ((state == IDLE && start) || kill) begin
      pass <= 1'b0;
    end else if (state == FLUSH) begin
      pass <= (sig_fold == SIG_EXP);
    end
  end

  adder_bist_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == SETUP),
    .en    (cap_vld && !kill),
    .din   ({co_q, resp_q}),
    .sig   (signature)
  );

endmodule
